// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: next-PC select codes,
// default vectors and the sequential-address helper.
package mips_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;
  localparam logic [2:0] PCSRC_IRQ = 3'd4;
  localparam logic [2:0] PCSRC_EXC = 3'd5;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

  // The carry out of bit 30 is discarded so the supervisor bit survives.
  function automatic logic [31:0] seq_addr(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decoder <-> PC-stage connection. There is no valid/ready pair here: stall is
// the only flow control, and while it is high the PC stage ignores pc_src and holds.
interface pc_unit_if;
  logic        stall;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic        irq_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        irq_req;
  logic        kernel;

  modport master (
    output stall, pc_src, branch_taken, imm_ext, jump_target, jr_target, irq_in,
    input  pc, pc_plus4, link_addr, irq_req, kernel
  );

  modport slave (
    input  stall, pc_src, branch_taken, imm_ext, jump_target, jr_target, irq_in,
    output pc, pc_plus4, link_addr, irq_req, kernel
  );
endinterface

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and pending flag for the level timer interrupt.
// Everything freezes while en is low so a stalled cycle neither sees nor loses an edge.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic irq_in,
  input  logic take,
  output logic pending
);

  logic irq_d;
  logic irq_rise;

  assign irq_rise = irq_in & ~irq_d;

  // A rise in the same cycle as take is a fresh event and re-arms pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d   <= 1'b0;
      pending <= 1'b0;
    end else if (en) begin
      irq_d   <= irq_in;
      pending <= (pending & ~take) | irq_rise;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register with supervisor bit, next-PC select,
// interrupt request generation and link address for write-back.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  pc_unit_if.slave    bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_sum;
  logic [31:0] pc_next;
  logic        pending;
  logic        irq_req;
  logic        take;

  assign pc_plus4 = seq_addr(pc_q);
  assign br_sum   = pc_plus4 + {bus.imm_ext[29:0], 2'b00};
  assign irq_req  = pending & ~pc_q[31] & ~bus.stall;
  assign take     = ~bus.stall & irq_req;

  // Branch and jump keep pc[31]; only jr may clear it.
  always_comb begin
    pc_next = EXC_VEC;
    case (bus.pc_src)
      PCSRC_SEQ: pc_next = pc_plus4;
      PCSRC_BR:  pc_next = bus.branch_taken
                           ? ((br_sum & 32'h7FFF_FFFF) | {pc_q[31], 31'd0})
                           : pc_plus4;
      PCSRC_J:   pc_next = {pc_q[31], pc_plus4[30:28], bus.jump_target, 2'b00};
      PCSRC_JR:  pc_next = bus.jr_target;
      PCSRC_IRQ: pc_next = IRQ_VEC;
      default:   pc_next = EXC_VEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else if (!bus.stall) begin
      pc_q <= pc_next;
    end
  end

  irq_edge_latch u_irq (
    .clk     (clk),
    .reset   (reset),
    .en      (~bus.stall),
    .irq_in  (bus.irq_in),
    .take    (take),
    .pending (pending)
  );

  // On an interrupt the interrupted instruction re-executes after return.
  assign bus.link_addr = irq_req ? pc_q : pc_plus4;
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.irq_req   = irq_req;
  assign bus.kernel    = pc_q[31];

endmodule
